// File: rtl/led_seq_ctrl.sv
// Pattern-table LED sequencer: steps through {rep, div} entries, loading each divider
// into an external blink counter and advancing after rep counted LED toggles.
module led_seq_ctrl #(
    parameter int NSTEP = 8
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        cfg_we_i,
    input  logic [2:0]  cfg_addr_i,
    input  logic [19:0] cfg_data_i,
    input  logic [2:0]  len_i,
    input  logic        loop_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        led_i,
    output logic [11:0] div_o,
    output logic        wren_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  step_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [19:0] r_table [NSTEP];
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic [11:0] r_div;
    logic [7:0]  r_rep;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [7:0]  w_cnt_inc;
    logic        r_led_d;
    logic        r_first;
    logic [19:0] w_entry;
    logic        w_tog;
    logic        w_count;
    logic        w_step_end;

    assign w_entry    = (int'(r_idx) < NSTEP) ? r_table[r_idx] : '0;
    assign w_tog      = led_i ^ r_led_d;
    // The flip seen in the first RUN cycle is the blink counter reacting to wren_o.
    assign w_count    = (r_state == S_RUN) && w_tog && !r_first;
    assign w_cnt_inc  = r_cnt + 8'd1;
    // rep == 0 matches once the 8-bit counter wraps, i.e. after 256 toggles.
    assign w_step_end = w_count && (w_cnt_inc == r_rep);

    assign div_o  = (r_state == S_LOAD) ? w_entry[11:0] : r_div;
    assign step_o = r_idx;

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_cnt_next = r_cnt;
        wren_o     = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_idx_next = '0;
                    w_next     = S_LOAD;
                end
            end
            S_LOAD: begin
                wren_o     = 1'b1;
                busy_o     = 1'b1;
                w_cnt_next = '0;
                w_next     = S_RUN;
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (w_count) w_cnt_next = w_cnt_inc;
                if (w_step_end) begin
                    if (r_idx < len_i) begin
                        w_idx_next = r_idx + 3'd1;
                        w_next     = S_LOAD;
                    end else if (loop_i) begin
                        w_idx_next = '0;
                        w_next     = S_LOAD;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (stop_i) begin
            w_next     = S_IDLE;
            w_idx_next = r_idx;
            w_cnt_next = r_cnt;
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_table <= '{default: '0};
            r_idx   <= '0;
            r_div   <= '0;
            r_rep   <= '0;
            r_cnt   <= '0;
            r_led_d <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_led_d <= led_i;
            r_first <= (r_state == S_LOAD);
            // rep is latched with div so a table rewrite mid-step only affects the next load.
            if (r_state == S_LOAD) begin
                r_div <= w_entry[11:0];
                r_rep <= w_entry[19:12];
            end
            if (cfg_we_i && (int'(cfg_addr_i) < NSTEP)) r_table[cfg_addr_i] <= cfg_data_i;
        end
    end

endmodule
